// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
// Bundles the scanner's control inputs and display outputs.
//   master : drives en/load/value/dp_in/blank_lz, observes the display lines
//   slave  : the scanner itself
//   en        scan enable (0 = dark, scan frozen)
//   load      one-cycle strobe capturing value/dp_in into the pending buffer
//   value     4*NUM_DIGITS hex value, nibble i -> digit i (digit 0 rightmost)
//   dp_in     per-digit decimal point, 1 = lit
//   blank_lz  suppress leading zeros
//   an        active-low anode select
//   seg       active-low segments {g,f,e,d,c,b,a}
//   dp        active-low decimal point
//   digit_idx index of the digit currently driven
//   commit    one-cycle pulse when pending data becomes displayed
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [IW-1:0]           digit_idx;
    logic                    commit;

    modport master (
        output en, load, value, dp_in, blank_lz,
        input  an, seg, dp, digit_idx, commit
    );

    modport slave (
        input  en, load, value, dp_in, blank_lz,
        output an, seg, dp, digit_idx, commit
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// One digit is driven per REFRESH_DIV-cycle slot; new values are held in a
// pending buffer and only committed when the scan wraps back to digit 0, so a
// frame never mixes old and new digits.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seven_seg_scanner_if.slave (controls in, display lines out)
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scanner_if.slave   bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
    localparam int VW = 4 * NUM_DIGITS;

    // active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         disp_val, pend_val;
    logic [NUM_DIGITS-1:0] disp_dp, pend_dp;
    logic                  pend_v;
    logic                  commit_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;

    logic                  tick, wrap, do_commit;
    logic [IW-1:0]         idx_nx;
    logic [VW-1:0]         val_nx;
    logic [NUM_DIGITS-1:0] dpv_nx;
    logic [3:0]            nib;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [6:0]            seg_nx;
    logic                  dp_nx;

    assign tick      = bus.en && (pcnt == PMAX);
    assign wrap      = tick && (idx == IMAX);
    assign do_commit = wrap && (bus.load || pend_v);
    assign idx_nx    = !tick ? idx : (idx == IMAX) ? '0 : idx + 1'b1;

    // Value that will be on display after this edge; a load landing on the
    // wrap tick skips the buffer so it appears in the same cycle.
    always_comb begin
        val_nx = disp_val;
        dpv_nx = disp_dp;
        if (wrap && bus.load) begin
            val_nx = bus.value;
            dpv_nx = bus.dp_in;
        end else if (wrap && pend_v) begin
            val_nx = pend_val;
            dpv_nx = pend_dp;
        end
    end

    // Outputs are computed from next-state index/value so they move on the
    // tick edge itself rather than one cycle later.
    always_comb begin
        nib    = val_nx[4*int'(idx_nx) +: 4];
        // digit and everything above it zero <=> value shifted down is zero
        blank  = bus.blank_lz && (idx_nx != '0) && ((val_nx >> (4*int'(idx_nx))) == '0);
        an_nx  = ~(NUM_DIGITS'(1) << idx_nx);
        seg_nx = blank ? 7'h7F : ~hex7(nib);
        dp_nx  = ~dpv_nx[idx_nx];
        if (!bus.en) begin
            an_nx  = '1;
            seg_nx = 7'h7F;
            dp_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            idx      <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
            commit_r <= 1'b0;
            an_r     <= ~NUM_DIGITS'(1);
            seg_r    <= 7'h40;
            dp_r     <= 1'b1;
        end else begin
            if (bus.en)
                pcnt <= tick ? '0 : pcnt + 1'b1;
            idx      <= idx_nx;
            disp_val <= val_nx;
            disp_dp  <= dpv_nx;
            commit_r <= do_commit;
            if (do_commit) begin
                pend_v <= 1'b0;
            end else if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp_in;
                pend_v   <= 1'b1;
            end
            an_r  <= an_nx;
            seg_r <= seg_nx;
            dp_r  <= dp_nx;
        end
    end

    assign bus.an        = an_r;
    assign bus.seg       = seg_r;
    assign bus.dp        = dp_r;
    assign bus.digit_idx = idx;
    assign bus.commit    = commit_r;
endmodule
